// File: rtl/layer_sequencer_pkg.sv
// layer_sequencer_pkg: state/mode codes and decode helpers for the layer sequencer.
package layer_sequencer_pkg;
  localparam int STATE_LEN = 4;
  localparam int MODE_LEN = 2;
  localparam int N_RUNS = 10;
  typedef enum logic [STATE_LEN-1:0] {
    S_IDLE, S_RECV, S_EMB, S_MIX, S_TANH, S_DENS_F, S_SEND,
    S_DENS_B, S_TANH_B, S_MIX_B, S_EMB_B, S_FIN, S_ERR
  } state_e;
  typedef enum logic [MODE_LEN-1:0] {M_TRAIN, M_FORWARD, M_GEN_NEW} mode_e;
  function automatic logic is_wait(state_e s);
    return s inside {S_RECV, S_EMB, S_MIX, S_TANH, S_SEND, S_TANH_B, S_MIX_B, S_EMB_B};
  endfunction
  // Bit order: recv, emb_f, mix_f, tanh_f, dens_f, send, dens_b, tanh_b, mix_b, emb_b (MSB first).
  function automatic logic [N_RUNS-1:0] run_decode(state_e s);
    logic [N_RUNS-1:0] r;
    r = '0;
    case (s)
      S_RECV:   r[9] = 1'b1;
      S_EMB:    r[8] = 1'b1;
      S_MIX:    r[7] = 1'b1;
      S_TANH:   r[6] = 1'b1;
      S_DENS_F: r[5] = 1'b1;
      S_SEND:   r[4] = 1'b1;
      S_DENS_B: r[3] = 1'b1;
      S_TANH_B: r[2] = 1'b1;
      S_MIX_B:  r[1] = 1'b1;
      S_EMB_B:  r[0] = 1'b1;
      default:  r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: saturating cycle counter that flags expiry once limit waiting cycles have elapsed.
module seq_watchdog #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expired_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != '1) ? cnt_q + TO_W'(1) : cnt_q;
  // Fires during the limit-th waiting cycle so the state lasts exactly limit cycles.
  assign expired_o = enable_i && limit_i != '0 && cnt_q >= limit_i - TO_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps forward/backward passes through N_LAYERS mix/tanh layers with watchdog.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int N_LAYERS = 3,
  parameter int LIDX_W = 3,
  parameter int TO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MODE_LEN-1:0]  mode,
  input  logic                 ack,
  input  logic                 abort,
  input  logic [TO_W-1:0]      to_limit,
  input  logic                 recv_valid,
  input  logic                 emb_valid_f,
  input  logic                 mix_valid_f,
  input  logic                 tanh_valid_f,
  input  logic                 send_valid,
  input  logic                 mix_valid_b,
  input  logic                 tanh_valid_b,
  input  logic                 emb_valid_b,
  output logic                 recv_run,
  output logic                 emb_run_f,
  output logic                 mix_run_f,
  output logic                 tanh_run_f,
  output logic                 dens_run_f,
  output logic                 send_run,
  output logic                 dens_run_b,
  output logic                 tanh_run_b,
  output logic                 mix_run_b,
  output logic                 emb_run_b,
  output logic [LIDX_W-1:0]    layer_idx,
  output logic [STATE_LEN-1:0] state,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam logic [LIDX_W-1:0] LAST = LIDX_W'(N_LAYERS - 1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [LIDX_W-1:0] lidx_q, lidx_d;
  logic [N_RUNS-1:0] run_q, run_d;
  logic done_q, done_d, error_q, error_d, expired;
  seq_watchdog #(.TO_W(TO_W)) u_wdog (
    .clk(clk), .rst(rst), .clear_i(state_d != state_q), .enable_i(is_wait(state_q)),
    .limit_i(to_limit), .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    lidx_d = lidx_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode_e'(mode);
        state_d = mode_e'(mode) == M_GEN_NEW ? S_MIX : S_RECV;
        lidx_d = mode_e'(mode) == M_GEN_NEW ? LAST : '0;
      end
      S_RECV: if (recv_valid) begin
        state_d = S_EMB;
        lidx_d = '0;
      end
      S_EMB:    if (emb_valid_f) state_d = S_MIX;
      S_MIX:    if (mix_valid_f) state_d = S_TANH;
      S_TANH: if (tanh_valid_f) begin
        state_d = lidx_q < LAST ? S_MIX : S_DENS_F;
        lidx_d = lidx_q < LAST ? lidx_q + LIDX_W'(1) : lidx_q;
      end
      S_DENS_F: state_d = S_SEND;
      S_SEND:   if (send_valid) state_d = mode_q == M_TRAIN ? S_DENS_B : S_FIN;
      S_DENS_B: begin
        state_d = S_TANH_B;
        lidx_d = LAST;
      end
      S_TANH_B: if (tanh_valid_b) state_d = S_MIX_B;
      S_MIX_B: if (mix_valid_b) begin
        state_d = lidx_q != '0 ? S_TANH_B : S_EMB_B;
        lidx_d = lidx_q != '0 ? lidx_q - LIDX_W'(1) : lidx_q;
      end
      S_EMB_B:  if (emb_valid_b) state_d = S_FIN;
      S_FIN:    if (ack) state_d = S_IDLE;
      S_ERR:    if (ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // A valid arriving in the expiry cycle still advances; abort overrides everything.
    if (expired && state_d == state_q) state_d = S_ERR;
    if (abort) state_d = S_IDLE;
    if (state_d == S_IDLE) lidx_d = '0;
    run_d = run_decode(state_d);
    done_d = state_d == S_FIN && state_q != S_FIN;
    error_d = (state_q == S_ERR && ack) ? 1'b0 : (state_d == S_ERR) ? 1'b1 : error_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      mode_q <= M_TRAIN;
      lidx_q <= '0;
      run_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      lidx_q <= lidx_d;
      run_q <= run_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  assign {recv_run, emb_run_f, mix_run_f, tanh_run_f, dens_run_f,
          send_run, dens_run_b, tanh_run_b, mix_run_b, emb_run_b} = run_q;
  assign layer_idx = lidx_q;
  assign state = state_q;
  assign busy = !(state_q inside {S_IDLE, S_FIN, S_ERR});
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: random-latency passes checked against a per-mode expected visit list, plus directed corner cases.
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst, start, ack, abort;
  logic [1:0] mode;
  logic [15:0] to_limit;
  logic [7:0] vld;
  logic recv_run, emb_run_f, mix_run_f, tanh_run_f, dens_run_f, send_run, dens_run_b, tanh_run_b, mix_run_b, emb_run_b;
  logic [2:0] layer_idx;
  logic [3:0] state;
  logic busy, done, error;
  logic [9:0] runs;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  assign runs = {recv_run, emb_run_f, mix_run_f, tanh_run_f, dens_run_f, send_run, dens_run_b, tanh_run_b, mix_run_b, emb_run_b};
  layer_sequencer #(.N_LAYERS(N), .LIDX_W(3), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ack(ack), .abort(abort), .to_limit(to_limit),
    .recv_valid(vld[0]), .emb_valid_f(vld[1]), .mix_valid_f(vld[2]), .tanh_valid_f(vld[3]),
    .send_valid(vld[4]), .mix_valid_b(vld[5]), .tanh_valid_b(vld[6]), .emb_valid_b(vld[7]),
    .recv_run(recv_run), .emb_run_f(emb_run_f), .mix_run_f(mix_run_f), .tanh_run_f(tanh_run_f),
    .dens_run_f(dens_run_f), .send_run(send_run), .dens_run_b(dens_run_b), .tanh_run_b(tanh_run_b),
    .mix_run_b(mix_run_b), .emb_run_b(emb_run_b), .layer_idx(layer_idx), .state(state),
    .busy(busy), .done(done), .error(error)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int vidx(logic [3:0] s);
    case (s)
      S_RECV: return 0;
      S_EMB: return 1;
      S_MIX: return 2;
      S_TANH: return 3;
      S_SEND: return 4;
      S_MIX_B: return 5;
      S_TANH_B: return 6;
      S_EMB_B: return 7;
      default: return -1;
    endcase
  endfunction
  function automatic logic [9:0] exp_runs(logic [3:0] s);
    case (s)
      S_RECV: return 10'b1000000000;
      S_EMB: return 10'b0100000000;
      S_MIX: return 10'b0010000000;
      S_TANH: return 10'b0001000000;
      S_DENS_F: return 10'b0000100000;
      S_SEND: return 10'b0000010000;
      S_DENS_B: return 10'b0000001000;
      S_TANH_B: return 10'b0000000100;
      S_MIX_B: return 10'b0000000010;
      S_EMB_B: return 10'b0000000001;
      default: return 10'b0;
    endcase
  endfunction
  task automatic advance_to(input logic [3:0] tgt);
    int t = 0;
    while (state != tgt && t < 200) begin
      vld = '0;
      if (vidx(state) >= 0) vld[vidx(state)] = 1'b1;
      @(negedge clk);
      t++;
    end
    vld = '0;
    chk("advance_reach", state, tgt);
  endtask
  task automatic begin_pass(input logic [1:0] m);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run_pass(input logic [1:0] m);
    logic [3:0] es[$];
    int el[$];
    logic [3:0] prev;
    int cyc = 0, wait_n = 0, dones = 0, k;
    if (m != M_GEN_NEW) begin
      es.push_back(S_RECV); el.push_back(0);
      es.push_back(S_EMB); el.push_back(0);
      for (int l = 0; l < N; l++) begin
        es.push_back(S_MIX); el.push_back(l);
        es.push_back(S_TANH); el.push_back(l);
      end
    end else begin
      es.push_back(S_MIX); el.push_back(N - 1);
      es.push_back(S_TANH); el.push_back(N - 1);
    end
    es.push_back(S_DENS_F); el.push_back(N - 1);
    es.push_back(S_SEND); el.push_back(N - 1);
    if (m == M_TRAIN) begin
      es.push_back(S_DENS_B); el.push_back(N - 1);
      for (int l = N - 1; l >= 0; l--) begin
        es.push_back(S_TANH_B); el.push_back(l);
        es.push_back(S_MIX_B); el.push_back(l);
      end
      es.push_back(S_EMB_B); el.push_back(0);
      es.push_back(S_FIN); el.push_back(0);
    end else begin
      es.push_back(S_FIN); el.push_back(N - 1);
    end
    chk("pass_idle", state, S_IDLE);
    begin_pass(m);
    prev = S_IDLE;
    for (int t = 0; t < 400; t++) begin
      if (done) dones++;
      if (state != prev) begin
        if (es.size() == 0) chk("extra_state", state, S_IDLE);
        else begin
          chk("seq_state", state, es[0]);
          chk("seq_layer", layer_idx, el[0]);
          chk("seq_runs", runs, exp_runs(es[0]));
          chk("seq_busy", busy, es[0] != S_FIN);
          void'(es.pop_front());
          void'(el.pop_front());
        end
        prev = state;
        cyc = 0;
        wait_n = $urandom_range(0, 3);
        if (state == S_FIN) begin
          chk("done_on_fin", done, 1);
          break;
        end
      end
      vld = '0;
      if (vidx(state) >= 0 && cyc == wait_n) vld[vidx(state)] = 1'b1;
      else if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 7);
        if (k != vidx(state)) vld[k] = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    vld = '0;
    chk("pass_complete", es.size(), 0);
    chk("done_pulses", dones, 1);
    if (state == S_FIN) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("fin_ignores_start", state, S_FIN);
      chk("done_single", done, 0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("fin_ack_idle", state, S_IDLE);
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0; vld = '0; mode = '0; to_limit = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_layer", layer_idx, 0);
    chk("rst_runs", runs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", state, S_IDLE);
    chk("start_abort_busy", busy, 0);
    run_pass(M_TRAIN);
    run_pass(M_GEN_NEW);
    run_pass(M_FORWARD);
    repeat (8) begin
      to_limit = $urandom_range(0, 1) ? 16'd0 : 16'd50;
      run_pass(2'($urandom_range(0, 2)));
    end
    to_limit = 16'd10;
    begin_pass(M_GEN_NEW);
    n = 0;
    while (state == S_MIX && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("wd_mix_cycles", n, 10);
    chk("wd_err_state", state, S_ERR);
    chk("wd_error_set", error, 1);
    chk("wd_err_busy", busy, 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("wd_ack_idle", state, S_IDLE);
    chk("wd_ack_clear", error, 0);
    to_limit = 16'd0;
    begin_pass(M_FORWARD);
    advance_to(S_TANH);
    vld[3] = 1'b1; abort = 1'b1;
    @(negedge clk);
    vld = '0; abort = 1'b0;
    chk("abort_idle", state, S_IDLE);
    chk("abort_layer", layer_idx, 0);
    chk("abort_runs", runs, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done_next", done, 0);
    to_limit = 16'd3;
    begin_pass(M_GEN_NEW);
    n = 0;
    while (state != S_ERR && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("wd2_err", state, S_ERR);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("err_abort_idle", state, S_IDLE);
    chk("error_sticky", error, 1);
    to_limit = 16'd0;
    begin_pass(M_TRAIN);
    advance_to(S_TANH_B);
    chk("tanh_b_layer", layer_idx, N - 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", state, S_IDLE);
    chk("midrst_layer", layer_idx, 0);
    chk("midrst_runs", runs, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", state, S_IDLE);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
